// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the serial frame transmitter.
//   tx_state_t : frame phase (idle, sync word, payload, idle gap)
//   DEF_*      : default frame geometry
//   cnt_width  : width of the per-phase down-counter
package seq_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } tx_state_t;

  localparam int         DEF_SYNC_W   = 4;
  localparam logic [3:0] DEF_SYNC_PAT = 4'b0101;
  localparam int         DEF_DATA_W   = 8;
  localparam int         DEF_GAP      = 2;

  // The counter only ever holds (phase length - 1).
  // The floor of 2 keeps it at least one bit wide.
  function automatic int cnt_width(input int sync_w, input int data_w, input int gap);
    int m;
    m = 2;
    if (sync_w > m) m = sync_w;
    if (data_w > m) m = data_w;
    if (gap > m) m = gap;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// Payload shift register: parallel load, shift left, MSB drives the line.
//   clk   : rising-edge clock
//   load  : capture din (takes priority over shift)
//   shift : move contents one bit toward the MSB
//   din   : parallel payload
//   msb   : current most significant bit
module seq_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sh_p0;

  // Pure datapath: contents are don't-care until the next load, so no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      sh_p0 <= din;
    end else if (shift) begin
      sh_p0 <= sh_p0 << 1;
    end
  end

  assign msb = sh_p0[DATA_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter. Each accepted word is sent MSB-first, one bit per
// clock, as: sync word, payload, forced-idle gap. The line idles high.
//   clk   : rising-edge clock
//   rst   : asynchronous, active-low reset
//   valid : producer has a word on din
//   din   : payload, taken on valid && ready
//   ready : transmitter is idle and can accept a word
//   j     : serial line, 1 when idle
//   busy  : a frame is in progress
//   done  : one-cycle pulse in the cycle after the last payload bit
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int                SYNC_W   = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                GAP      = DEF_GAP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              j,
  output logic              busy,
  output logic              done
);

  localparam int CW = cnt_width(SYNC_W, DATA_W, GAP);

  localparam logic [CW-1:0] SYNC_LD = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LD = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP > 0) ? CW'(GAP - 1) : '0;

  tx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              load, shift;
  logic              data_bit;
  logic [SYNC_W-1:0] sync_sh;

  seq_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk   (clk),
    .load  (load),
    .shift (shift),
    .din   (din),
    .msb   (data_bit)
  );

  // State, counter and done pulse all abort asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // ready is high throughout IDLE, so valid alone completes the handshake.
        if (valid) begin
          load    = 1'b1;
          cnt_d   = SYNC_LD;
          state_d = S_SYNC;
        end
      end
      S_SYNC: begin
        if (cnt_q == '0) begin
          cnt_d   = DATA_LD;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        shift = 1'b1;
        if (cnt_q == '0) begin
          done_d = 1'b1;
          if (GAP > 0) begin
            cnt_d   = GAP_LD;
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The counter runs down from SYNC_W-1, so the shifted-down pattern's
  // LSB is the sync bit for this cycle, MSB first.
  assign sync_sh = SYNC_PAT >> cnt_q;

  always_comb begin
    ready = 1'b0;
    busy  = 1'b1;
    j     = 1'b1;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      S_SYNC:  j = sync_sh[0];
      S_DATA:  j = data_bit;
      S_GAP:   j = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign done = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: default geometry (instance a) and a
// short-payload, no-gap geometry (instance b) sharing clock and reset.
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst;
  logic       valid_a, ready_a, j_a, busy_a, done_a;
  logic [7:0] din_a;
  logic       valid_b, ready_b, j_b, busy_b, done_b;
  logic [3:0] din_b;

  int n_cmp;
  int n_err;
  int hits;

  seq_pattern_tx u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .valid (valid_a),
    .din   (din_a),
    .ready (ready_a),
    .j     (j_a),
    .busy  (busy_a),
    .done  (done_a)
  );

  seq_pattern_tx #(
    .SYNC_W   (4),
    .SYNC_PAT (4'b0101),
    .DATA_W   (4),
    .GAP      (0)
  ) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .valid (valid_b),
    .din   (din_b),
    .ready (ready_b),
    .j     (j_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walks one default-geometry frame starting in the first sync cycle and
  // ends in the following IDLE cycle (15 cycles after the accept edge).
  // inj_at >= 0 pulses valid with din=FF for one cycle mid-frame.
  // hits counts 0101 windows on j, as an overlapping detector would.
  task automatic frame_a(input string tag, input logic [13:0] bits,
                         input int inj_at, output int nhits);
    logic [3:0] hist;
    hist  = 4'hF;
    nhits = 0;
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("%s_j%0d", tag, i), 32'(j_a), 32'(bits[13-i]));
      chk($sformatf("%s_done%0d", tag, i), 32'(done_a), 32'(i == 12));
      chk($sformatf("%s_rdy_busy%0d", tag, i), 32'({ready_a, busy_a}), 32'(2'b01));
      hist = {hist[2:0], j_a};
      if (hist == 4'b0101) nhits++;
      if (inj_at >= 0 && i == inj_at) begin
        valid_a = 1'b1;
        din_a   = 8'hFF;
      end else if (inj_at >= 0 && i == inj_at + 1) begin
        valid_a = 1'b0;
      end
      step();
    end
    chk($sformatf("%s_idle", tag), 32'({ready_a, j_a, busy_a, done_a}), 32'(4'b1100));
  endtask

  // Instance b: 4 sync + 4 payload bits, done lands in the IDLE cycle.
  task automatic frame_b(input string tag, input logic [7:0] bits, output int nhits);
    logic [3:0] hist;
    hist  = 4'hF;
    nhits = 0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_j%0d", tag, i), 32'(j_b), 32'(bits[7-i]));
      chk($sformatf("%s_st%0d", tag, i), 32'({ready_b, busy_b, done_b}), 32'(3'b010));
      hist = {hist[2:0], j_b};
      if (hist == 4'b0101) nhits++;
      step();
    end
    chk($sformatf("%s_idle_done", tag), 32'({ready_b, j_b, busy_b, done_b}), 32'(4'b1101));
    step();
    chk($sformatf("%s_idle", tag), 32'({ready_b, j_b, busy_b, done_b}), 32'(4'b1100));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    valid_a = 1'b0;
    din_a   = 8'h00;
    valid_b = 1'b0;
    din_b   = 4'h0;

    // Reset asserted and held for 3 clocks
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_a", 32'({ready_a, j_a, busy_a, done_a}), 32'(4'b1100));
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_hold_a%0d", i), 32'({ready_a, j_a, busy_a, done_a}), 32'(4'b1100));
      chk($sformatf("rst_hold_b%0d", i), 32'({ready_b, j_b, busy_b, done_b}), 32'(4'b1100));
    end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("idle_a%0d", i), 32'({ready_a, j_a, busy_a, done_a}), 32'(4'b1100));
      chk($sformatf("idle_b%0d", i), 32'({ready_b, j_b, busy_b, done_b}), 32'(4'b1100));
    end

    // Single frame A5: 0101 10100101 11
    valid_a = 1'b1;
    din_a   = 8'hA5;
    step();
    valid_a = 1'b0;
    frame_a("a5", 14'b0101_10100101_11, -1, hits);

    // Back-to-back with valid held: 0F then F0, accepts 15 edges apart
    valid_a = 1'b1;
    din_a   = 8'h0F;
    step();
    frame_a("b2b_0f", 14'b0101_00001111_11, -1, hits);
    din_a = 8'hF0;
    step();
    valid_a = 1'b0;
    frame_a("b2b_f0", 14'b0101_11110000_11, -1, hits);

    // valid pulse with FF mid-frame is ignored
    valid_a = 1'b1;
    din_a   = 8'h96;
    step();
    valid_a = 1'b0;
    frame_a("ign_96", 14'b0101_10010110_11, 5, hits);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ign_no_frame%0d", i), 32'({ready_a, j_a, busy_a, done_a}), 32'(4'b1100));
    end

    // Abort during the 3rd payload bit of C3 (cycle index 6)
    valid_a = 1'b1;
    din_a   = 8'hC3;
    step();
    valid_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      logic [13:0] c3_bits;
      c3_bits = 14'b0101_11000011_11;
      chk($sformatf("abort_pre_j%0d", i), 32'(j_a), 32'(c3_bits[13-i]));
      if (i < 6) step();
    end
    #2;
    rst = 1'b0;
    #1;
    chk("abort_async", 32'({ready_a, j_a, busy_a, done_a}), 32'(4'b1100));
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("abort_hold%0d", i), 32'({ready_a, j_a, busy_a, done_a}), 32'(4'b1100));
    end
    rst = 1'b1;
    step();
    chk("abort_release", 32'({ready_a, j_a, busy_a, done_a}), 32'(4'b1100));
    valid_a = 1'b1;
    din_a   = 8'h3C;
    step();
    valid_a = 1'b0;
    frame_a("post_abort_3c", 14'b0101_00111100_11, -1, hits);

    // Loopback through an overlapping 0101 detector model
    valid_a = 1'b1;
    din_a   = 8'h00;
    step();
    valid_a = 1'b0;
    frame_a("lp_00", 14'b0101_00000000_11, -1, hits);
    chk("lp_00_hits", 32'(hits), 32'd1);

    valid_a = 1'b1;
    din_a   = 8'h50;
    step();
    valid_a = 1'b0;
    frame_a("lp_50", 14'b0101_01010000_11, -1, hits);
    chk("lp_50_hits", 32'(hits), 32'd3);

    // Short geometry: DATA_W=4, GAP=0
    valid_b = 1'b1;
    din_b   = 4'h0;
    step();
    valid_b = 1'b0;
    frame_b("b_0", 8'b0101_0000, hits);
    chk("b_0_hits", 32'(hits), 32'd1);

    valid_b = 1'b1;
    din_b   = 4'h5;
    step();
    valid_b = 1'b0;
    frame_b("b_5", 8'b0101_0101, hits);
    chk("b_5_hits", 32'(hits), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
